nn_layer_sequencer: RTL and testbench

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

---
 rtl/nn_layer_sequencer_if.sv | 28 ++
 rtl/nn_layer_sequencer.sv | 119 +++++++++++
 tb/tb_nn_layer_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer and its layer/argmax datapaths.
// master = sequencer side, slave = datapath/environment side.
interface nn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int WIDTH      = 8
);
  logic                  start;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_enable;
  logic                  stage_reset;
  logic                  max_enable;
  logic                  max_done;
  logic [WIDTH-1:0]      max_digit;
  logic [WIDTH-1:0]      digit;
  logic                  valid;
  logic                  busy;
  logic                  error;

  modport master (
    input  start, layer_done, max_done, max_digit,
    output layer_enable, stage_reset, max_enable, digit, valid, busy, error
  );

  modport slave (
    output start, layer_done, max_done, max_digit,
    input  layer_enable, stage_reset, max_enable, digit, valid, busy, error
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Sequences NUM_LAYERS fully-connected layers then an argmax stage, with a
// per-stage watchdog timer. Every output is a register loaded from next-state.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  nn_layer_sequencer_if.master bus
);
  localparam int KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_LAYERS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_ARGMAX,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [KW-1:0]         r_k, w_k_nxt;
  logic [TW-1:0]         r_timer, w_timer_nxt;
  logic [WIDTH-1:0]      r_digit, w_digit_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [NUM_LAYERS-1:0] r_layer_en, w_layer_en_nxt;
  logic                  r_stage_rst, r_max_en, r_busy, r_error;
  logic                  w_timeout;

  assign w_timeout = (r_timer == T_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_timer_nxt = r_timer;
    w_digit_nxt = r_digit;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          w_state_nxt = S_CLEAR;
          w_valid_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_RUN;
        w_k_nxt     = '0;
        w_timer_nxt = '0;
      end
      S_RUN: begin
        // done is checked before the timeout so a same-cycle done wins
        if (bus.layer_done[r_k]) begin
          w_timer_nxt = '0;
          if (r_k == K_LAST) w_state_nxt = S_ARGMAX;
          else               w_k_nxt     = r_k + 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_ARGMAX: begin
        if (bus.max_done) begin
          w_state_nxt = S_DONE;
          w_digit_nxt = bus.max_digit;
          w_valid_nxt = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_layer_en_nxt = '0;
    if (w_state_nxt == S_RUN) w_layer_en_nxt = NUM_LAYERS'(1) << w_k_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_timer     <= '0;
      r_digit     <= '0;
      r_valid     <= 1'b0;
      r_layer_en  <= '0;
      r_stage_rst <= 1'b0;
      r_max_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_timer     <= w_timer_nxt;
      r_digit     <= w_digit_nxt;
      r_valid     <= w_valid_nxt;
      r_layer_en  <= w_layer_en_nxt;
      r_stage_rst <= (w_state_nxt == S_CLEAR);
      r_max_en    <= (w_state_nxt == S_ARGMAX);
      r_busy      <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_RUN) ||
                     (w_state_nxt == S_ARGMAX);
      r_error     <= (w_state_nxt == S_ERROR);
    end
  end

  assign bus.layer_enable = r_layer_en;
  assign bus.stage_reset  = r_stage_rst;
  assign bus.max_enable   = r_max_en;
  assign bus.digit        = r_digit;
  assign bus.valid        = r_valid;
  assign bus.busy         = r_busy;
  assign bus.error        = r_error;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench: table of inference scenarios driven through a reactive
// layer/argmax responder, digits checked through a scoreboard queue.
module tb_nn_layer_sequencer;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nn_layer_sequencer_if #(.NUM_LAYERS(3), .WIDTH(8)) bus ();

  nn_layer_sequencer #(.NUM_LAYERS(3), .WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    int         d0, d1, d2, dm;   // cycles after enable before done; >TMO-1 means never
    logic [7:0] md;
    bit         inj;              // pulse start while layer 1 runs
    bit         spur;             // spurious layer_done[2] while layer 0 runs
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] last_digit = '0;

  int         dly[4];
  logic [7:0] mdig = '0;
  logic [2:0] spur = '0;
  int         rcnt = 0;
  logic [3:0] prev_r = '0;

  // Responder: counts cycles since the current enable appeared, raises done on cue
  always @(negedge clk) begin
    logic [3:0] cur;
    logic [2:0] ld;
    cur = {bus.max_enable, bus.layer_enable};
    if (cur != prev_r) rcnt = 0;
    else               rcnt = rcnt + 1;
    prev_r = cur;
    ld = '0;
    for (int i = 0; i < 3; i++)
      if (bus.layer_enable[i] && rcnt == dly[i]) ld[i] = 1'b1;
    bus.layer_done = ld | (bus.layer_enable[0] ? spur : 3'b000);
    bus.max_done   = bus.max_enable && (rcnt == dly[3]);
    bus.max_digit  = mdig;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int stage_dly(input vec_t v, input int s);
    case (s)
      0: return v.d0;
      1: return v.d1;
      2: return v.d2;
      default: return v.dm;
    endcase
  endfunction

  // Latency in negedges from the one where start is driven to valid/error visible
  function automatic int exp_lat(input vec_t v, output bit is_err);
    int sum = 2;
    is_err = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (stage_dly(v, s) > TMO - 1) begin
        is_err = 1'b1;
        return sum + TMO;
      end
      sum += stage_dly(v, s) + 1;
    end
    return sum;
  endfunction

  task automatic run(input vec_t v);
    bit         exp_err;
    int         elat, lat, e2, srn;
    logic [11:0] seq;
    logic [2:0] prev_en;
    bit         inj_done, inj_clr;
    logic [7:0] expd;
    lat = 0; e2 = -1; srn = 0; seq = '0; prev_en = '0; inj_done = 0; inj_clr = 0;
    dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2; dly[3] = v.dm;
    mdig = v.md;
    spur = v.spur ? 3'b100 : 3'b000;
    elat = exp_lat(v, exp_err);
    if (!exp_err) sb.push_back(v.md);

    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; lat = 1;
    chk({v.name, "/clear_stage_reset"}, bus.stage_reset, 1);
    chk({v.name, "/clear_busy"}, bus.busy, 1);
    chk({v.name, "/clear_error"}, bus.error, 0);
    chk({v.name, "/clear_valid"}, bus.valid, 0);
    while (1) begin
      if (bus.stage_reset) srn++;
      if (bus.layer_enable != prev_en && bus.layer_enable != 3'b000)
        seq = {seq[7:0], 1'b0, bus.layer_enable};
      prev_en = bus.layer_enable;
      if (bus.layer_enable == 3'b100 && e2 < 0) e2 = lat;
      if (inj_clr) begin bus.start = 1'b0; inj_clr = 0; end
      if (v.inj && !inj_done && bus.layer_enable == 3'b010) begin
        bus.start = 1'b1; inj_done = 1; inj_clr = 1;
      end
      if (bus.valid || bus.error || lat >= 400) break;
      @(negedge clk); lat++;
    end
    bus.start = 1'b0;
    spur = '0;

    chk({v.name, "/latency"}, lat, elat);
    chk({v.name, "/error"}, bus.error, exp_err);
    chk({v.name, "/valid"}, bus.valid, !exp_err);
    chk({v.name, "/busy"}, bus.busy, 0);
    chk({v.name, "/layer_enable"}, bus.layer_enable, 0);
    chk({v.name, "/max_enable"}, bus.max_enable, 0);
    if (exp_err) begin
      chk({v.name, "/digit_kept"}, bus.digit, last_digit);
      if (v.d0 < TMO && v.d1 < TMO && v.d2 >= TMO)
        chk({v.name, "/timeout_cycles"}, lat - e2, TMO);
    end else begin
      if (sb.size() == 0) begin
        chk({v.name, "/sb_underflow"}, 1, 0);
      end else begin
        expd = sb.pop_front();
        chk({v.name, "/digit"}, bus.digit, expd);
        last_digit = expd;
      end
      chk({v.name, "/enable_order"}, seq, 12'h124);
      chk({v.name, "/stage_reset_cycles"}, srn, 1);
    end
    repeat (3) @(negedge clk);
    chk({v.name, "/hold_digit"}, bus.digit, last_digit);
    chk({v.name, "/hold_valid"}, bus.valid, !exp_err);
    chk({v.name, "/hold_error"}, bus.error, exp_err);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"nominal",      5, 5, 5, 11, 8'd7,   0, 0};
    vecs[1] = '{"start_in_run", 5, 5, 5, 11, 8'd7,   1, 0};
    vecs[2] = '{"immediate",    0, 0, 0, 0,  8'd3,   0, 0};
    vecs[3] = '{"done_wins",    2, 15, 1, 15, 8'd200, 0, 0};
    vecs[4] = '{"timeout_l2",   1, 2, 255, 0, 8'd99,  0, 0};
    vecs[5] = '{"recover",      0, 3, 0, 2,  8'd42,  0, 0};
    vecs[6] = '{"spurious",     8, 0, 0, 0,  8'd9,   0, 1};
    vecs[7] = '{"timeout_l0",   255, 0, 0, 0, 8'd11, 0, 0};
    vecs[8] = '{"timeout_max",  0, 0, 0, 255, 8'd12, 0, 0};
    vecs[9] = '{"after_errors", 1, 1, 1, 1,  8'h55,  0, 0};

    for (int i = 0; i < 4; i++) dly[i] = 0;
    bus.start = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset/busy", bus.busy, 0);
    chk("reset/error", bus.error, 0);
    chk("reset/valid", bus.valid, 0);
    chk("reset/digit", bus.digit, 0);
    chk("reset/layer_enable", bus.layer_enable, 0);
    chk("reset/stage_reset", bus.stage_reset, 0);
    chk("reset/max_enable", bus.max_enable, 0);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle/busy", bus.busy, 0);

    for (int i = 0; i < 10; i++) run(vecs[i]);

    // Reset while the argmax stage is active
    dly[0] = 0; dly[1] = 0; dly[2] = 0; dly[3] = 255;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int n = 0; n < 50 && !bus.max_enable; n++) @(negedge clk);
    chk("rst_argmax/reached", bus.max_enable, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_argmax/max_enable", bus.max_enable, 0);
    chk("rst_argmax/busy", bus.busy, 0);
    chk("rst_argmax/digit", bus.digit, 0);
    chk("rst_argmax/valid", bus.valid, 0);
    chk("rst_argmax/error", bus.error, 0);
    chk("rst_argmax/layer_enable", bus.layer_enable, 0);
    chk("rst_argmax/stage_reset", bus.stage_reset, 0);
    last_digit = '0;
    @(negedge clk);
    chk("rst_argmax/stays_idle", bus.busy, 0);

    run(vecs[0]);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
